// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants for the per-queue flow-control FIFOs
package fc_pkg;

    localparam int FC_DATA_W = 6;

    // Pointer widths per queue class (depth = 2**addr_w)
    localparam int MF_ADDR_W = 2;
    localparam int VC_ADDR_W = 4;
    localparam int D_ADDR_W  = 2;

    // Bit positions of each queue inside the control FSM status buses
    localparam int STATUS_MF  = 4;
    localparam int STATUS_VC0 = 3;
    localparam int STATUS_VC1 = 2;
    localparam int STATUS_D0  = 1;
    localparam int STATUS_D1  = 0;
    localparam int NUM_QUEUES = 5;

    typedef enum logic [2:0] {
        Q_D1  = 3'd0,
        Q_D0  = 3'd1,
        Q_VC1 = 3'd2,
        Q_VC0 = 3'd3,
        Q_MF  = 3'd4
    } queue_id_t;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - dual-port register array, synchronous write, registered read
module fifo_mem
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_DATA_W,
    parameter int ADDR_W = MF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset; stale words are never visible because reads follow the pointers
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between accepted reads; a same-address write returns the old word
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_flow_control.sv
// rtl/fifo_flow_control.sv - per-queue FIFO with threshold flags and sticky error
module fifo_flow_control
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_DATA_W,
    parameter int ADDR_W = MF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [ADDR_W-1:0] umbral_ae,
    input  logic [ADDR_W-1:0] umbral_af,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              error,
    output logic [ADDR_W:0]   count
);

    localparam int              CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(fifo_depth(ADDR_W));

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] ae_q;
    logic [ADDR_W-1:0] af_q;
    logic [CNT_W-1:0]  count_q;
    logic              error_q;
    logic              valid_q;

    logic run;
    logic pop_ok;
    logic push_ok;
    logic overflow;
    logic underflow;

    // Accept decisions use the pre-edge count; a pop frees the slot a same-cycle push needs
    always_comb begin
        run       = reset && !init;
        pop_ok    = run && pop && (count_q != '0);
        push_ok   = run && push && ((count_q < DEPTH) || pop_ok);
        overflow  = run && push && full && !pop;
        underflow = run && pop && empty;
    end

    // Pointer, occupancy, threshold and read-valid state
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ae_q    <= '0;
            af_q    <= '0;
            valid_q <= 1'b0;
        end else if (init) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ae_q    <= umbral_ae;
            af_q    <= umbral_af;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error survives init; only reset clears it
    always_ff @(posedge clk) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else if (overflow || underflow) begin
            error_q <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH);
    assign almost_empty = (count_q <= {1'b0, ae_q});
    assign almost_full  = (count_q >= {1'b0, af_q});
    assign error        = error_q;
    assign valid_out    = valid_q;
    assign count        = count_q;

endmodule
